// File: rtl/pp_mode_ctrl_pkg.sv
// Shared preprocessing types: pixel width, mode encodings, controller FSM states.
package pp_mode_ctrl_pkg;

    localparam int PIX_W = 12;

    localparam logic MODE_COLOUR = 1'b0;
    localparam logic MODE_GREY   = 1'b1;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Mode that takes effect at a start of frame, given any waiting request.
    function automatic logic apply_mode(input logic cur, input logic pend, input logic pend_mode);
        return pend ? pend_mode : cur;
    endfunction

endpackage

// File: rtl/pp_mode_ctrl_if.sv
// Mode-controller bus: upstream pixels, mode requests, greyscale-unit ports and aligned output.
interface pp_mode_ctrl_if import pp_mode_ctrl_pkg::*; #(parameter int DW = PIX_W);

    logic          mode_req;
    logic          mode_stb;
    logic          mode;
    logic          mode_pend;
    logic          src_valid;
    logic          src_sof;
    logic [DW-1:0] src_data;
    logic          gs_valid;
    logic [DW-1:0] gs_data;
    logic          gs_ret_valid;
    logic [DW-1:0] gs_ret_data;
    logic          dst_valid;
    logic          dst_sof;
    logic [DW-1:0] dst_data;
    logic [15:0]   frame_cnt;
    logic          err;

    modport master (
        output mode_req, mode_stb, src_valid, src_sof, src_data, gs_ret_valid, gs_ret_data,
        input  mode, mode_pend, gs_valid, gs_data, dst_valid, dst_sof, dst_data, frame_cnt, err
    );

    modport slave (
        input  mode_req, mode_stb, src_valid, src_sof, src_data, gs_ret_valid, gs_ret_data,
        output mode, mode_pend, gs_valid, gs_data, dst_valid, dst_sof, dst_data, frame_cnt, err
    );

endinterface

// File: rtl/pp_delay_line.sv
// Fixed-depth shift register, DEPTH cycles of latency, no backpressure (always shifts).
module pp_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/pp_mode_ctrl.sv
// Per-frame colour/greyscale selection with latency-matched merge; 2+GS_LAT cycles in both modes.
// No backpressure: every accepted pixel emerges, bubbles preserved one-for-one.
module pp_mode_ctrl import pp_mode_ctrl_pkg::*; #(
    parameter int   DW           = PIX_W,
    parameter int   GS_LAT       = 1,
    parameter logic DEFAULT_MODE = MODE_COLOUR
) (
    input  logic            clk,
    input  logic            rst,
    pp_mode_ctrl_if.slave   bus
);

    typedef struct packed {
        logic          sel;
        logic          sof;
        logic          valid;
        logic [DW-1:0] data;
    } tag_t;

    state_t        state, state_nxt;
    logic          mode_q, pend_q, pend_mode_q;
    logic          sof_acc, accept, mode_eff;
    logic          eff_pend, eff_pend_mode;
    logic [15:0]   frame_cnt_q;
    logic          gs_valid_q;
    logic [DW-1:0] gs_data_q;
    logic          dst_valid_q, dst_sof_q, err_q;
    logic [DW-1:0] dst_data_q;
    tag_t          tag_in, tag_out;

    always_ff @(posedge clk) begin
        if (rst) state <= SYNC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == SYNC && sof_acc) state_nxt = RUN;
    end

    // A strobe coinciding with an accepted SOF counts as already pending.
    always_comb begin
        sof_acc       = bus.src_valid & bus.src_sof;
        accept        = bus.src_valid & ((state == RUN) | bus.src_sof);
        eff_pend      = bus.mode_stb | pend_q;
        eff_pend_mode = bus.mode_stb ? bus.mode_req : pend_mode_q;
        mode_eff      = sof_acc ? apply_mode(mode_q, eff_pend, eff_pend_mode) : mode_q;
        tag_in        = '{sel: mode_eff, sof: sof_acc, valid: accept, data: bus.src_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= DEFAULT_MODE;
            pend_q      <= 1'b0;
            pend_mode_q <= 1'b0;
            frame_cnt_q <= '0;
            gs_valid_q  <= 1'b0;
            gs_data_q   <= '0;
        end else begin
            mode_q <= mode_eff;
            if (sof_acc) begin
                pend_q <= 1'b0;
            end else if (bus.mode_stb) begin
                pend_q      <= 1'b1;
                pend_mode_q <= bus.mode_req;
            end
            if (sof_acc) frame_cnt_q <= frame_cnt_q + 16'd1;
            gs_valid_q <= accept & mode_eff;
            gs_data_q  <= bus.src_data;
        end
    end

    pp_delay_line #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (1 + GS_LAT)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d   (tag_in),
        .q   (tag_out)
    );

    // Tail of the tag line lines up with the greyscale unit's return.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_valid_q <= 1'b0;
            dst_sof_q   <= 1'b0;
            dst_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            dst_valid_q <= tag_out.valid;
            dst_sof_q   <= tag_out.valid & tag_out.sof;
            if (!tag_out.valid)   dst_data_q <= '0;
            else if (tag_out.sel) dst_data_q <= bus.gs_ret_data;
            else                  dst_data_q <= tag_out.data;
            if ((tag_out.valid & tag_out.sel) != bus.gs_ret_valid) err_q <= 1'b1;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.mode_pend = pend_q;
    assign bus.gs_valid  = gs_valid_q;
    assign bus.gs_data   = gs_data_q;
    assign bus.dst_valid = dst_valid_q;
    assign bus.dst_sof   = dst_sof_q;
    assign bus.dst_data  = dst_data_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_pp_mode_ctrl.sv
// Directed bench for pp_mode_ctrl with a one-cycle greyscale unit model (replicates G nibble).
module tb_pp_mode_ctrl;
    import pp_mode_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic drop = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic        lv [512];
    logic        ls [512];
    logic        lg [512];
    logic [11:0] ld [512];

    typedef struct packed {
        logic        sof;
        logic        stb;
        logic        req;
        logic [11:0] d;
        logic [11:0] exp_d;
        logic        exp_mode;
        logic        exp_pend;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    pp_mode_ctrl_if #(.DW(12)) bus ();

    pp_mode_ctrl #(
        .DW           (12),
        .GS_LAT       (1),
        .DEFAULT_MODE (MODE_COLOUR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (rst) begin
            bus.gs_ret_valid <= 1'b0;
            bus.gs_ret_data  <= '0;
        end else begin
            bus.gs_ret_valid <= bus.gs_valid & ~drop;
            bus.gs_ret_data  <= {bus.gs_data[7:4], bus.gs_data[7:4], bus.gs_data[7:4]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [11:0] d,
                        input logic stb, input logic req);
        bus.src_valid = v;
        bus.src_sof   = s;
        bus.src_data  = d;
        bus.mode_stb  = stb;
        bus.mode_req  = req;
        @(posedge clk);
        #1;
        lv[cyc] = bus.dst_valid;
        ls[cyc] = bus.dst_sof;
        ld[cyc] = bus.dst_data;
        lg[cyc] = bus.gs_valid;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    endtask

    function automatic int cnt_v(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) n += int'(lv[i]);
        return n;
    endfunction

    function automatic int cnt_g(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) n += int'(lg[i]);
        return n;
    endfunction

    initial begin
        int k0, ka, kb, kt, kr;

        tbl = '{
            '{1'b0, 1'b1, 1'b1, 12'h111, 12'h111, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 12'h222, 12'h222, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 12'h345, 12'h444, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 12'h9C1, 12'hCCC, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0, 12'h5E7, 12'h5E7, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 12'h123, 12'h123, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 12'h456, 12'h456, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 12'h789, 12'h888, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0, 12'hABC, 12'hBBB, 1'b1, 1'b1},
            '{1'b1, 1'b0, 1'b0, 12'hDEF, 12'hDEF, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 12'h0F0, 12'h0F0, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 12'h777, 12'h777, 1'b0, 1'b0}
        };

        rst = 1'b1;
        idle(2);
        chk("rst_mode",  32'(bus.mode), 32'd0);
        chk("rst_pend",  32'(bus.mode_pend), 32'd0);
        chk("rst_valid", 32'(bus.dst_valid), 32'd0);
        chk("rst_gs",    32'(bus.gs_valid), 32'd0);
        chk("rst_cnt",   32'(bus.frame_cnt), 32'd0);
        chk("rst_err",   32'(bus.err), 32'd0);
        rst = 1'b0;

        // pixels before the first SOF are dropped
        k0 = cyc;
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 12'(i), 1'b0, 1'b0);
        ka = cyc;
        for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 12'h100 + 12'(i), 1'b0, 1'b0);
        idle(3);
        chk("sync_count", 32'(cnt_v(k0, cyc)), 32'd5);
        chk("sof_valid",  32'(lv[ka+2]), 32'd1);
        chk("sof_flag",   32'(ls[ka+2]), 32'd1);
        chk("sof_data",   32'(ld[ka+2]), 32'h100);
        chk("last_data",  32'(ld[ka+6]), 32'h104);
        chk("mid_sof",    32'(ls[ka+3]), 32'd0);
        chk("cnt_one",    32'(bus.frame_cnt), 32'd1);

        kb = cyc;
        step(1'b1, 1'b0, 12'hA53, 1'b0, 1'b0);
        idle(3);
        chk("lat_early", 32'(lv[kb+1]), 32'd0);
        chk("lat_zero",  32'(ld[kb+1]), 32'd0);
        chk("lat_valid", 32'(lv[kb+2]), 32'd1);
        chk("lat_data",  32'(ld[kb+2]), 32'hA53);
        chk("lat_late",  32'(lv[kb+3]), 32'd0);
        chk("colour_gs", 32'(cnt_g(k0, cyc)), 32'd0);

        // back-to-back pixels, mode requests, seams with no bubbles
        kt = cyc;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i].sof, tbl[i].d, tbl[i].stb, tbl[i].req);
            chk($sformatf("mode_%0d", i), 32'(bus.mode), 32'(tbl[i].exp_mode));
            chk($sformatf("pend_%0d", i), 32'(bus.mode_pend), 32'(tbl[i].exp_pend));
            chk($sformatf("gsv_%0d", i),  32'(lg[cyc-1]), 32'(tbl[i].exp_mode));
        end
        idle(3);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("out_v_%0d", i), 32'(lv[kt+i+2]), 32'd1);
            chk($sformatf("out_d_%0d", i), 32'(ld[kt+i+2]), 32'(tbl[i].exp_d));
            chk($sformatf("out_s_%0d", i), 32'(ls[kt+i+2]), 32'(tbl[i].sof));
        end
        chk("cnt_six",  32'(bus.frame_cnt), 32'd6);
        chk("err_none", 32'(bus.err), 32'd0);

        // greyscale unit loses one valid
        step(1'b1, 1'b1, 12'h321, 1'b1, 1'b1);
        drop = 1'b1;
        step(1'b1, 1'b0, 12'h654, 1'b0, 1'b0);
        drop = 1'b0;
        chk("err_before", 32'(bus.err), 32'd0);
        step(1'b1, 1'b0, 12'h111, 1'b0, 1'b0);
        chk("err_set", 32'(bus.err), 32'd1);
        idle(3);
        chk("err_sticky", 32'(bus.err), 32'd1);

        // reset mid-frame
        step(1'b1, 1'b1, 12'h222, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h234, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0, 12'h333, 1'b0, 1'b0);
        chk("mrst_valid", 32'(bus.dst_valid), 32'd0);
        chk("mrst_data",  32'(bus.dst_data), 32'd0);
        chk("mrst_gs",    32'(bus.gs_valid), 32'd0);
        chk("mrst_err",   32'(bus.err), 32'd0);
        chk("mrst_cnt",   32'(bus.frame_cnt), 32'd0);
        chk("mrst_mode",  32'(bus.mode), 32'd0);
        rst = 1'b0;
        kr = cyc;
        step(1'b1, 1'b0, 12'h444, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h555, 1'b0, 1'b0);
        idle(4);
        chk("mrst_drain", 32'(cnt_v(kr, cyc)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
